multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 276 +++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of a multicycle MIPS-style datapath.
//
// Walks the fetch / decode / execute / memory / writeback sequence for
// lw, sw, R-type, beq, addi and (optionally) j. Every datapath strobe and
// mux select is decoded combinationally from the current state, the opcode
// and mem_ready. The current state is exported on the state port so that
// external checkers can follow the sequence.
//
// Configuration macro: MULTICYCLE_JUMP_EN
//   defined   -> opcode 000010 (j) runs through JEX (PC <= jump target).
//   undefined -> opcode 000010 is rejected like any unsupported opcode,
//                and the JEX encoding is treated as an unused state.
//
// Handshake: mem_ready qualifies the memory access presented in the same
// cycle. FETCH, MEMRD and MEMWR keep their request asserted and hold the
// state until a cycle where mem_ready=1; the access (and, in FETCH, the
// IR/PC update) is taken in exactly that cycle.

module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] OP,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemToReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUOP,
    output logic [3:0] state,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BEQEX  = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JEX    = 4'd11
    } state_t;

    // Opcodes understood by the decoder.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // ALUSrcB selects.
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_ONE   = 2'b01;
    localparam logic [1:0] SRCB_SEXT  = 2'b10;
    localparam logic [1:0] SRCB_SEXTS = 2'b11;

    // PCSrc selects.
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // ALU operation codes.
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;

    state_t cur_state;
    state_t nxt_state;

    logic op_is_mem;
    logic op_is_rtype;
    logic op_is_beq;
    logic op_is_addi;
    logic op_is_j;
    logic op_legal;

    // Opcode classification used by the DECODE branch and the illegal flag.
    always_comb begin
        op_is_mem   = (OP == OP_LW) || (OP == OP_SW);
        op_is_rtype = (OP == OP_RTYPE);
        op_is_beq   = (OP == OP_BEQ);
        op_is_addi  = (OP == OP_ADDI);
`ifdef MULTICYCLE_JUMP_EN
        op_is_j     = (OP == OP_J);
`else
        op_is_j     = 1'b0;
`endif
        op_legal    = op_is_mem | op_is_rtype | op_is_beq | op_is_addi | op_is_j;
    end

    // State register; synchronous active-low reset wins over any transition,
    // including a pending memory wait.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state logic.
    always_comb begin
        nxt_state = S_FETCH;
        case (cur_state)
            S_FETCH: begin
                nxt_state = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                if (op_is_mem) begin
                    nxt_state = S_MEMADR;
                end else if (op_is_rtype) begin
                    nxt_state = S_RTEX;
                end else if (op_is_beq) begin
                    nxt_state = S_BEQEX;
                end else if (op_is_addi) begin
                    nxt_state = S_ADDIEX;
                end else if (op_is_j) begin
                    nxt_state = S_JEX;
                end else begin
                    nxt_state = S_FETCH;
                end
            end
            S_MEMADR: begin
                nxt_state = (OP == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                nxt_state = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                nxt_state = S_FETCH;
            end
            S_MEMWR: begin
                nxt_state = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_RTEX: begin
                nxt_state = S_RTWB;
            end
            S_RTWB: begin
                nxt_state = S_FETCH;
            end
            S_BEQEX: begin
                nxt_state = S_FETCH;
            end
            S_ADDIEX: begin
                nxt_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                nxt_state = S_FETCH;
            end
`ifdef MULTICYCLE_JUMP_EN
            S_JEX: begin
                nxt_state = S_FETCH;
            end
`endif
            default: begin
                // Unused encodings (and JEX when jumps are disabled) recover
                // to FETCH on the next edge.
                nxt_state = S_FETCH;
            end
        endcase
    end

    // Output decode: everything defaults to 0, each state raises only what
    // it names. Outputs are forced low while reset is held.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        PCSrc       = PC_ALU;
        ALUOP       = ALU_ADD;
        illegal_op  = 1'b0;
        if (rst_n) begin
            case (cur_state)
                S_FETCH: begin
                    // PC+1 on the ALU while the instruction word is read;
                    // IR and PC only load once memory delivers.
                    MemRead = 1'b1;
                    IorD    = 1'b0;
                    ALUSrcA = 1'b0;
                    ALUSrcB = SRCB_ONE;
                    ALUOP   = ALU_ADD;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        PCSrc   = PC_ALU;
                    end
                end
                S_DECODE: begin
                    // Branch target precomputed speculatively into ALUOut.
                    ALUSrcA    = 1'b0;
                    ALUSrcB    = SRCB_SEXTS;
                    ALUOP      = ALU_ADD;
                    illegal_op = ~op_legal;
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_SEXT;
                    ALUOP   = ALU_ADD;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b0;
                    MemToReg = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_RTEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_REG;
                    ALUOP   = ALU_FUNCT;
                end
                S_RTWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                    MemToReg = 1'b0;
                end
                S_BEQEX: begin
                    ALUSrcA     = 1'b1;
                    ALUSrcB     = SRCB_REG;
                    ALUOP       = ALU_SUB;
                    PCWriteCond = 1'b1;
                    PCSrc       = PC_ALUOUT;
                end
                S_ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_SEXT;
                    ALUOP   = ALU_ADD;
                end
                S_ADDIWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b0;
                    MemToReg = 1'b0;
                end
`ifdef MULTICYCLE_JUMP_EN
                S_JEX: begin
                    PCWrite = 1'b1;
                    PCSrc   = PC_JUMP;
                end
`endif
                default: begin
                    // Unused encodings keep every output at its default 0.
                end
            endcase
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed literal checks of the multicycle control FSM,
// followed by a randomized instruction stream checked every cycle against an
// instruction-level model (per-instruction cycle lists built from opcode class,
// fetch waits and memory waits, with occasional mid-instruction resets).
// Build with +define+MULTICYCLE_JUMP_EN to exercise the jump option.

module tb_multicycle_ctrl;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic       mem_ready;

    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_op;
    logic [3:0] state;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .OP         (op),
        .mem_ready  (mem_ready),
        .PCWrite    (pc_write),
        .PCWriteCond(pc_write_cond),
        .IorD       (iord),
        .MemRead    (mem_read),
        .MemWrite   (mem_write),
        .IRWrite    (ir_write),
        .MemToReg   (mem_to_reg),
        .RegDst     (reg_dst),
        .RegWrite   (reg_write),
        .ALUSrcA    (alu_src_a),
        .ALUSrcB    (alu_src_b),
        .PCSrc      (pc_src),
        .ALUOP      (alu_op),
        .state      (state),
        .illegal_op (illegal_op)
    );

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;

    // Observed / expected output bundle; st in the top nibble.
    typedef struct packed {
        logic [3:0] st;
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
        logic [1:0] asb, pcs;
        logic [2:0] aop;
        logic       ill;
    } obs_t;

    typedef struct packed {
        logic [5:0] op;
        logic       mr;
        logic       rn;
        obs_t       exp;
    } step_t;

    // ---------------- scoreboard state ----------------
    logic [21:0] exp_q[$];
    step_t       plan[$];
    int          total = 0;
    int          bad   = 0;

    function automatic obs_t dut_obs();
        obs_t o;
        o.st   = state;     o.pcw  = pc_write;   o.pcwc = pc_write_cond;
        o.iord = iord;      o.mrd  = mem_read;   o.mwr  = mem_write;
        o.irw  = ir_write;  o.m2r  = mem_to_reg; o.rdst = reg_dst;
        o.rw   = reg_write; o.asa  = alu_src_a;  o.asb  = alu_src_b;
        o.pcs  = pc_src;    o.aop  = alu_op;     o.ill  = illegal_op;
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Inputs change on the falling edge; outputs are sampled 2 ns later,
    // well away from the rising edge.
    task automatic cyc(input logic [5:0] o, input logic mr, input logic rn);
        @(negedge clk);
        op        = o;
        mem_ready = mr;
        rst_n     = rn;
        #2;
    endtask

    // ---------------- behavioural model ----------------
    function automatic obs_t mk(input logic [3:0] st);
        obs_t e;
        e    = '0;
        e.st = st;
        return e;
    endfunction

    // 0 illegal, 1 lw, 2 sw, 3 R-type, 4 beq, 5 addi, 6 j
    function automatic int classify(input logic [5:0] o);
        case (o)
            LW:      return 1;
            SW:      return 2;
            RT:      return 3;
            BEQ:     return 4;
            ADDI:    return 5;
`ifdef MULTICYCLE_JUMP_EN
            JMP:     return 6;
`endif
            default: return 0;
        endcase
    endfunction

    function automatic logic [5:0] rnd_op();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Build the cycle-by-cycle expectation for one instruction.
    task automatic gen_instr(input logic [5:0] iop, input int wf, input int wm);
        step_t q[$];
        obs_t  e;
        int    cls;
        cls = classify(iop);
        // fetch: wf wait cycles, then the completing cycle
        for (int w = 0; w <= wf; w++) begin
            e = mk(4'd0); e.mrd = 1'b1; e.asb = 2'b01;
            if (w == wf) begin e.irw = 1'b1; e.pcw = 1'b1; end
            q.push_back('{rnd_op(), (w == wf), 1'b1, e});
        end
        // decode
        e = mk(4'd1); e.asb = 2'b11; e.ill = (cls == 0);
        q.push_back('{iop, rnd_bit(), 1'b1, e});
        case (cls)
            1, 2: begin
                e = mk(4'd2); e.asa = 1'b1; e.asb = 2'b10;
                q.push_back('{iop, rnd_bit(), 1'b1, e});
                for (int w = 0; w <= wm; w++) begin
                    e = mk((cls == 1) ? 4'd3 : 4'd5); e.iord = 1'b1;
                    if (cls == 1) e.mrd = 1'b1; else e.mwr = 1'b1;
                    q.push_back('{rnd_op(), (w == wm), 1'b1, e});
                end
                if (cls == 1) begin
                    e = mk(4'd4); e.rw = 1'b1; e.m2r = 1'b1;
                    q.push_back('{rnd_op(), rnd_bit(), 1'b1, e});
                end
            end
            3: begin
                e = mk(4'd6); e.asa = 1'b1; e.aop = 3'b010;
                q.push_back('{rnd_op(), rnd_bit(), 1'b1, e});
                e = mk(4'd7); e.rw = 1'b1; e.rdst = 1'b1;
                q.push_back('{rnd_op(), rnd_bit(), 1'b1, e});
            end
            4: begin
                e = mk(4'd8); e.asa = 1'b1; e.aop = 3'b001; e.pcwc = 1'b1; e.pcs = 2'b01;
                q.push_back('{rnd_op(), rnd_bit(), 1'b1, e});
            end
            5: begin
                e = mk(4'd9); e.asa = 1'b1; e.asb = 2'b10;
                q.push_back('{rnd_op(), rnd_bit(), 1'b1, e});
                e = mk(4'd10); e.rw = 1'b1;
                q.push_back('{rnd_op(), rnd_bit(), 1'b1, e});
            end
            6: begin
                e = mk(4'd11); e.pcw = 1'b1; e.pcs = 2'b10;
                q.push_back('{rnd_op(), rnd_bit(), 1'b1, e});
            end
            default: ;
        endcase
        // Occasionally abort with reset: that cycle shows its state with all
        // other outputs 0, and the next instruction starts from FETCH.
        if ($urandom_range(0, 7) == 0) begin
            int k;
            k = $urandom_range(0, q.size() - 1);
            q[k].rn  = 1'b0;
            q[k].exp = mk(q[k].exp.st);
            q = q[0:k];
        end
        foreach (q[i]) plan.push_back(q[i]);
    endtask

    // ---------------- stimulus + checks ----------------
    initial begin
        obs_t o;
        int   lw_st[6] = '{0, 1, 2, 3, 4, 0};
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        op        = 6'd0;

        // reset held 2 cycles with mem_ready=1: FETCH, all strobes low
        for (int i = 0; i < 2; i++) begin
            cyc(RT, 1'b1, 1'b0);
            o = dut_obs();
            chk("rst_state", 32'(o.st), 32'd0);
            chk("rst_outs", 32'(o[17:0]), 32'd0);
        end

        // release, then lw with zero waits: states 0,1,2,3,4,0
        for (int i = 0; i < 6; i++) begin
            cyc(LW, 1'b1, 1'b1);
            o = dut_obs();
            chk("lw_state", 32'(o.st), 32'(lw_st[i]));
            chk("lw_regwrite", 32'(o.rw), 32'(lw_st[i] == 4));
            chk("lw_memtoreg", 32'(o.m2r), 32'(lw_st[i] == 4));
            if (i == 0) begin
                chk("rel_irwrite", 32'(o.irw), 32'd1);
                chk("rel_pcwrite", 32'(o.pcw), 32'd1);
                chk("rel_memread", 32'(o.mrd), 32'd1);
            end
        end

        // sw with 3 wait cycles in MEMWR
        cyc(SW, 1'b1, 1'b1); chk("sw_dec", 32'(state), 32'd1);
        cyc(SW, 1'b1, 1'b1); chk("sw_adr", 32'(state), 32'd2);
        for (int k = 0; k < 4; k++) begin
            cyc(SW, (k == 3), 1'b1);
            chk("sw_wr_state", 32'(state), 32'd5);
            chk("sw_memwrite", 32'(mem_write), 32'd1);
            chk("sw_iord", 32'(iord), 32'd1);
        end
        cyc(SW, 1'b1, 1'b1); chk("sw_done", 32'(state), 32'd0);

        // beq
        cyc(BEQ, 1'b1, 1'b1); chk("beq_dec", 32'(state), 32'd1);
        cyc(BEQ, 1'b1, 1'b1);
        chk("beq_state", 32'(state), 32'd8);
        chk("beq_aluop", 32'(alu_op), 32'd1);
        chk("beq_pcwc", 32'(pc_write_cond), 32'd1);
        chk("beq_pcsrc", 32'(pc_src), 32'd1);
        cyc(BEQ, 1'b1, 1'b1); chk("beq_done", 32'(state), 32'd0);

        // R-type
        cyc(RT, 1'b1, 1'b1); chk("rt_dec", 32'(state), 32'd1);
        cyc(RT, 1'b1, 1'b1);
        chk("rt_ex", 32'(state), 32'd6);
        chk("rt_aluop", 32'(alu_op), 32'd2);
        cyc(RT, 1'b1, 1'b1);
        chk("rt_wb", 32'(state), 32'd7);
        chk("rt_regdst", 32'(reg_dst), 32'd1);
        chk("rt_regwrite", 32'(reg_write), 32'd1);
        cyc(RT, 1'b1, 1'b1); chk("rt_done", 32'(state), 32'd0);

        // unsupported opcode
        cyc(6'b111111, 1'b1, 1'b1);
        chk("ill_state", 32'(state), 32'd1);
        chk("ill_flag", 32'(illegal_op), 32'd1);
        chk("ill_nowrite", 32'({reg_write, mem_write, pc_write, pc_write_cond, ir_write}), 32'd0);
        cyc(6'b111111, 1'b1, 1'b1);
        chk("ill_back", 32'(state), 32'd0);
        chk("ill_pulse", 32'(illegal_op), 32'd0);

        // jump opcode
        cyc(JMP, 1'b1, 1'b1);
        chk("j_dec", 32'(state), 32'd1);
`ifdef MULTICYCLE_JUMP_EN
        chk("j_legal", 32'(illegal_op), 32'd0);
        cyc(JMP, 1'b1, 1'b1);
        chk("j_state", 32'(state), 32'd11);
        chk("j_pcwrite", 32'(pc_write), 32'd1);
        chk("j_pcsrc", 32'(pc_src), 32'd2);
`else
        chk("j_illegal", 32'(illegal_op), 32'd1);
`endif
        cyc(JMP, 1'b1, 1'b1); chk("j_done", 32'(state), 32'd0);

        // reset during a MEMRD wait
        cyc(LW, 1'b1, 1'b1); chk("rr_dec", 32'(state), 32'd1);
        cyc(LW, 1'b1, 1'b1); chk("rr_adr", 32'(state), 32'd2);
        cyc(LW, 1'b0, 1'b1);
        chk("rr_memrd", 32'(state), 32'd3);
        chk("rr_memread", 32'(mem_read), 32'd1);
        cyc(LW, 1'b0, 1'b0);
        chk("rr_hold_state", 32'(state), 32'd3);
        chk("rr_memread_rst", 32'(mem_read), 32'd0);
        chk("rr_outs_rst", 32'(dut_obs() & 22'h3ffff), 32'd0);
        cyc(LW, 1'b0, 1'b1);
        chk("rr_after", 32'(state), 32'd0);
        chk("rr_fetch_wait", 32'({mem_read, ir_write, pc_write}), 32'b100);

        // randomized instruction stream (DUT now waiting in FETCH)
        for (int n = 0; n < 80; n++) begin
            logic [5:0] iop;
            case ($urandom_range(0, 6))
                0: iop = LW;
                1: iop = SW;
                2: iop = RT;
                3: iop = BEQ;
                4: iop = ADDI;
                5: iop = JMP;
                default: iop = rnd_op();
            endcase
            gen_instr(iop, $urandom_range(0, 2), $urandom_range(0, 2));
        end
        foreach (plan[i]) exp_q.push_back(plan[i].exp);

        // single compare point per cycle against the model queue
        while (plan.size() > 0) begin
            step_t s;
            logic [21:0] e;
            s = plan.pop_front();
            e = exp_q.pop_front();
            cyc(s.op, s.mr, s.rn);
            chk($sformatf("rand_cycle op=%b mr=%b rn=%b", s.op, s.mr, s.rn),
                32'(dut_obs()), 32'(e));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
